// File: rtl/instr_seq.sv
// +----------------------------------------------------------------------------+
// | instr_seq : MSP430 multi-cycle fetch/operand sequencer, owns the IR.  r1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_seq #(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MDB_out,
  input  logic        mem_rdy,
  input  logic        halt,
  output logic [15:0] INSTR,
  output logic [1:0]  MAB_sel,
  output logic        MC,
  output logic        PC_inc,
  output logic        ext_src_ld,
  output logic        ext_dst_ld,
  output logic        op_src_ld,
  output logic        op_dst_ld,
  output logic        src_inc,
  output logic        RW,
  output logic        MW,
  output logic        BW,
  output logic        instr_done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_FETCH   = 3'd1,
    S_SRC_EXT = 3'd2,
    S_SRC_RD  = 3'd3,
    S_DST_EXT = 3'd4,
    S_DST_RD  = 3'd5,
    S_EXEC    = 3'd6,
    S_DST_WR  = 3'd7
  } state_t;

  localparam logic [1:0] C_HOLD_LAST = 2'(RESET_PC_HOLD - 1);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [1:0]  hold_q, hold_d;

  // In FETCH the routing decision must be made on the word arriving from memory.
  logic [15:0] w_word;
  logic [3:0]  w_op, w_src;
  logic [1:0]  w_as, w_src_mab;
  logic        w_fmt1, w_fmt2, w_has_src, w_ad, w_cg, w_imm;
  logic        w_src_ext, w_src_rd, w_dst_rd, w_cmpbit, w_dst_wr, w_rw;
  logic        w_unused_bw_bit;
  state_t      w_after_src_rd, w_after_src_ext, w_after_fetch;

  assign w_word          = (state_q == S_FETCH) ? MDB_out : instr_q;
  assign w_unused_bw_bit = w_word[6];
  assign w_op      = w_word[15:12];
  assign w_fmt2    = (w_op == 4'b0001);
  assign w_fmt1    = (w_op[3:2] != 2'b00);
  assign w_has_src = w_fmt1 | w_fmt2;
  assign w_as      = w_word[5:4];
  assign w_src     = w_fmt1 ? w_word[11:8] : w_word[3:0];
  assign w_ad      = w_fmt1 & w_word[7];
  assign w_cg      = (w_src == 4'd3) | ((w_src == 4'd2) & w_as[1]);
  assign w_imm     = w_has_src & (w_as == 2'b11) & (w_src == 4'd0);
  assign w_src_ext = w_has_src & (((w_as == 2'b01) & ~w_cg) | w_imm);
  assign w_src_rd  = w_has_src & (w_as != 2'b00) & ~w_cg & ~w_imm;
  assign w_dst_rd  = w_ad & (w_op != 4'h4);
  assign w_cmpbit  = (w_op == 4'h9) | (w_op == 4'hB);
  // Format II memory operands are read-modify-write at the source address.
  assign w_dst_wr  = (w_ad & ~w_cmpbit) | (w_fmt2 & w_src_rd);
  assign w_rw      = (w_fmt1 & ~w_ad & ~w_cmpbit) | (w_fmt2 & ~w_src_rd);
  assign w_src_mab = (w_as == 2'b01) ? ((w_src == 4'd2) ? 2'd3 : 2'd2) : 2'd1;

  assign w_after_src_rd  = w_ad ? S_DST_EXT : S_EXEC;
  assign w_after_src_ext = w_src_rd ? S_SRC_RD : w_after_src_rd;
  assign w_after_fetch   = w_src_ext ? S_SRC_EXT : w_after_src_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      instr_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    hold_d     = hold_q;
    MAB_sel    = 2'd0;
    MC         = 1'b0;
    PC_inc     = 1'b0;
    ext_src_ld = 1'b0;
    ext_dst_ld = 1'b0;
    op_src_ld  = 1'b0;
    op_dst_ld  = 1'b0;
    src_inc    = 1'b0;
    RW         = 1'b0;
    MW         = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_RST: begin
        if (hold_q == C_HOLD_LAST) begin
          state_d = S_FETCH;
          hold_d  = 2'd0;
        end else begin
          hold_d  = hold_q + 2'd1;
        end
      end
      S_FETCH: begin
        if (!halt && mem_rdy) begin
          PC_inc  = 1'b1;
          instr_d = MDB_out;
          state_d = w_after_fetch;
        end
      end
      S_SRC_EXT: begin
        if (mem_rdy) begin
          PC_inc     = 1'b1;
          op_src_ld  = w_imm;
          ext_src_ld = ~w_imm;
          state_d    = w_after_src_ext;
        end
      end
      S_SRC_RD: begin
        MAB_sel = w_src_mab;
        if (mem_rdy) begin
          op_src_ld = 1'b1;
          src_inc   = (w_as == 2'b11);
          state_d   = w_after_src_rd;
        end
      end
      S_DST_EXT: begin
        if (mem_rdy) begin
          PC_inc     = 1'b1;
          ext_dst_ld = 1'b1;
          state_d    = w_dst_rd ? S_DST_RD : S_EXEC;
        end
      end
      S_DST_RD: begin
        MAB_sel = 2'd2;
        MC      = 1'b1;
        if (mem_rdy) begin
          op_dst_ld = 1'b1;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        RW         = w_rw;
        instr_done = ~w_dst_wr;
        state_d    = w_dst_wr ? S_DST_WR : S_FETCH;
      end
      S_DST_WR: begin
        MAB_sel = w_fmt2 ? w_src_mab : 2'd2;
        MC      = ~w_fmt2;
        if (mem_rdy) begin
          MW         = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  assign INSTR = instr_q;
  assign state = state_q;
  assign BW    = ((instr_q[15:14] != 2'b00) | (instr_q[15:12] == 4'b0001)) & instr_q[6];

endmodule

`default_nettype wire

// File: doc/instr_seq.md
Name: instr_seq

Overview:
Multi-cycle fetch/operand sequencer for the MSP430 core. It owns the instruction register and walks each instruction through fetch, extension-word, operand-read, execute and write-back cycles. Each cycle it drives the MAB source select, the PC increment, operand latches and the RW/MW strobes. It sits between the memory bus (MAB/MDB) and the decoder/register file, and replaces ad-hoc "is MAB==PC" instruction detection with explicit states.

Parameters:
RESET_PC_HOLD, 1, cycles spent in RST state after reset release before the first FETCH (1..3)

Ports:
clk  input  1  core clock, all state changes on posedge
rst  input  1  asynchronous, active-high reset
MDB_out  input  16  memory read data
mem_rdy  input  1  memory access completes this cycle; data valid on MDB_out
halt  input  1  suppress new instruction fetch
INSTR  output  16  instruction register
MAB_sel  output  2  0=PC, 1=Sout (reg indirect), 2=CALC (reg+ext), 3=latched ext word (absolute)
MC  output  1  CALC ext select: 0=src ext, 1=dst ext
PC_inc  output  1  increment PC by 2 this cycle
ext_src_ld, ext_dst_ld  output  1 each  latch MDB_out as src/dst extension word
op_src_ld, op_dst_ld  output  1 each  latch MDB_out as src/dst operand
src_inc  output  1  autoincrement source register (+1 if BW, else +2)
RW  output  1  register file write
MW  output  1  memory write
BW  output  1  byte/word, INSTR[6] for Formats I/II, 0 for jumps
instr_done  output  1  one-cycle pulse on the final cycle of an instruction
state  output  3  current state, for debug

Behaviour:
- States: RST=0, FETCH=1, SRC_EXT=2, SRC_RD=3, DST_EXT=4, DST_RD=5, EXEC=6, DST_WR=7.
- Reset (async): state=RST, INSTR=0, all strobes 0, MAB_sel=0, MC=0, BW=0. After rst falls, stay in RST for RESET_PC_HOLD cycles, then go to FETCH.
- Memory states (FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD, DST_WR) hold until mem_rdy=1. All side-effect strobes (PC_inc, *_ld, src_inc, MW) fire only on the mem_rdy=1 cycle. MAB_sel is held stable for the whole wait.
- FETCH: MAB_sel=0.
  - If halt=1: hold with no PC_inc and no IR load.
  - Else on mem_rdy: INSTR<=MDB_out, PC_inc=1.
- Format decode of the newly loaded word:
  - 001x = jump
  - 0001 = Format II (operand reg = [3:0], As = [5:4])
  - >=0100 = Format I (src = [11:8], As = [5:4], Ad = [7], dst = [3:0])
  - Other encodings are executed as EXEC-only no-ops (RW=0).
- Source path, by As/src:
  - As=01, src not R3: go to SRC_EXT (MAB_sel=0, ext_src_ld, PC_inc), then SRC_RD.
  - SRC_RD address: MAB_sel=3 if src=R2 (absolute); MAB_sel=2 with MC=0 otherwise.
  - As=10, src not R2/R3: SRC_RD with MAB_sel=1.
  - As=11, src=R0 (immediate): SRC_EXT only; op_src_ld (not ext_src_ld) and PC_inc. No SRC_RD.
  - As=11, src not R0/R2/R3: SRC_RD with MAB_sel=1; src_inc on the completion cycle only.
  - As=00, or constant generator (src=R3 any As; src=R2 with As=10/11): no memory cycles.
- Destination path (Format I, Ad=1): DST_EXT (ext_dst_ld, PC_inc), then:
  - DST_RD (MAB_sel=2, MC=1, op_dst_ld), skipped for MOV (opcode 4).
  - Then EXEC, then DST_WR (MAB_sel=2, MC=1, MW=1 on mem_rdy).
- Format II with As=01/10/11 (non-constant source): result written back to the source address in DST_WR, reusing MC=0 / MAB_sel of SRC_RD.
- EXEC: single cycle, MAB_sel=0, no memory access.
  - RW=1 iff the destination is a register and the opcode is not CMP (9) or BIT (B). Jumps: RW=0.
  - CMP/BIT with a memory destination skip DST_WR.
- instr_done: asserted in EXEC if no DST_WR follows, else in the DST_WR completion cycle. The next state is FETCH.
- Order within an instruction is always src ext, src read, dst ext, dst read, exec, write. Every state not required by the addressing mode is skipped.
- Reset mid-instruction: abort immediately. No RW/MW is issued after rst rises, and a partially executed instruction is not resumed.

Test Plan:
1. Reset, then MOV R5,R6 (0x4506) with mem_rdy=1 -> states 0,1,6,1: one PC_inc in FETCH, RW=1 and instr_done in EXEC, 2 cycles per instruction.
2. ADD 2(R5),4(R6) (0x5596) with mem_rdy=1 -> states 1,2,3,4,5,6,7: PC_inc exactly 3 times, MC=0 in SRC_RD and MC=1 in DST_RD/DST_WR, MW=1 only in DST_WR, RW=0 throughout, instr_done in state 7.
3. MOV #0x1234,R7 (0x4037) -> states 1,2,6: op_src_ld in SRC_EXT, PC_inc twice, no src_inc. Then MOV #4,R6 (0x4226, constant generator) -> states 1,6 only.
4. MOV @R4+,R8 (0x4438) with mem_rdy held low for 3 cycles in SRC_RD -> state stays 3 with MAB_sel=1 stable, src_inc and op_src_ld pulse exactly once on the mem_rdy cycle.
5. CMP R5,R6 (0x9506) -> RW=0 in EXEC. CMP R5,4(R6) (0x9586) -> states 1,4,5,6: no DST_WR, MW never asserted.
6. Assert rst while in DST_RD of 0x5596 -> state=0 in the same cycle, INSTR=0, MW/RW stay 0. The first FETCH after release occurs RESET_PC_HOLD cycles later.
